// File: rtl/core_fetch_queue_pkg.sv
// Shared core types: instruction word, 30-bit word address and the fetch queue entry.
package core_fetch_queue_pkg;

  localparam logic [31:0] NOP_INSN = 32'he1a00000;

  typedef logic [31:0] word_t;
  typedef logic [29:0] ptr_t;

  typedef struct packed {
    word_t insn;
    ptr_t  pc;
  } fetch_entry_t;

endpackage

// File: rtl/core_fetch_fifo.sv
// Small prefetch FIFO of {word, pc} entries with synchronous clear.
module core_fetch_fifo
  import core_fetch_queue_pkg::*;
#(
  parameter int ORDER = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head_data,
  output logic         full,
  output logic         empty,
  output logic [ORDER:0] count
);

  localparam int DEPTH = 2 ** ORDER;

  fetch_entry_t mem [DEPTH];
  logic [ORDER-1:0] wr_ptr_reg;
  logic [ORDER-1:0] rd_ptr_reg;
  logic [ORDER:0]   count_reg;
  logic             wr_en;
  logic             rd_en;

  // A push into a full queue is only accepted when a pop frees the slot this cycle.
  assign wr_en = push && !clear && (!full || pop);
  assign rd_en = pop && !clear && !empty;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + (ORDER+1)'(wr_en) - (ORDER+1)'(rd_en);
    end
  end

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;
  assign empty     = (count_reg == '0);
  assign full      = (count_reg == (ORDER+1)'(DEPTH));

endmodule

// File: rtl/core_fetch_queue.sv
// Instruction fetch with single-outstanding bus reads, prefetch queue and flush redirect.
module core_fetch_queue
  import core_fetch_queue_pkg::*;
#(
  parameter int          ORDER = 2,
  parameter logic [31:0] NOP   = NOP_INSN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] target,
  output logic        start,
  output logic [29:0] addr,
  input  logic        ready,
  input  logic [31:0] data_rd,
  output logic [31:0] insn,
  output logic [29:0] insn_pc,
  output logic        nop
);

  localparam int DEPTH = 2 ** ORDER;

  ptr_t         fetch_pc_reg;
  ptr_t         req_pc_reg;
  logic         outstanding_reg;
  logic         discard_reg;
  word_t        insn_reg;
  ptr_t         insn_pc_reg;
  logic         nop_reg;

  fetch_entry_t q_head;
  fetch_entry_t q_push_data;
  logic         q_full;
  logic         q_empty;
  logic [ORDER:0] q_count;
  logic         q_push;
  logic         q_pop;

  logic         pop_slot;
  logic         resp;
  logic         resp_keep;
  logic         bypass;
  logic [ORDER+1:0] slots_needed;
  logic         space_ok;

  assign pop_slot  = !stall && !flush;
  assign q_pop     = pop_slot && !q_empty;
  assign resp      = ready && outstanding_reg;
  assign resp_keep = resp && !discard_reg && !flush;
  assign bypass    = pop_slot && q_empty && resp_keep;
  assign q_push    = resp_keep && !bypass;

  // Only issue if the word will have a slot when it returns, counting a pop this cycle.
  assign slots_needed = {1'b0, q_count} + {{(ORDER+1){1'b0}}, !q_pop};
  assign space_ok     = (slots_needed <= (ORDER+2)'(DEPTH));

  assign start = !rst && !outstanding_reg && !flush && space_ok;
  assign addr  = fetch_pc_reg;

  assign q_push_data = '{insn: data_rd, pc: req_pc_reg};

  core_fetch_fifo #(
    .ORDER(ORDER)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .push     (q_push),
    .push_data(q_push_data),
    .pop      (q_pop),
    .head_data(q_head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg    <= '0;
      req_pc_reg      <= '0;
      outstanding_reg <= 1'b0;
      discard_reg     <= 1'b0;
    end else begin
      if (flush) begin
        fetch_pc_reg <= target;
      end else if (start) begin
        fetch_pc_reg <= fetch_pc_reg + 1'b1;
        req_pc_reg   <= fetch_pc_reg;
      end

      if (resp) begin
        outstanding_reg <= 1'b0;
      end else if (start) begin
        outstanding_reg <= 1'b1;
      end

      // A request still in flight after the flush cycle returns a stale word.
      if (flush) begin
        discard_reg <= outstanding_reg && !ready;
      end else if (resp) begin
        discard_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      insn_reg    <= NOP;
      insn_pc_reg <= '0;
      nop_reg     <= 1'b1;
    end else if (flush) begin
      insn_reg <= NOP;
      nop_reg  <= 1'b1;
    end else if (!stall) begin
      if (!q_empty) begin
        insn_reg    <= q_head.insn;
        insn_pc_reg <= q_head.pc;
        nop_reg     <= 1'b0;
      end else if (resp_keep) begin
        insn_reg    <= data_rd;
        insn_pc_reg <= req_pc_reg;
        nop_reg     <= 1'b0;
      end else begin
        insn_reg <= NOP;
        nop_reg  <= 1'b1;
      end
    end
  end

  assign insn    = insn_reg;
  assign insn_pc = insn_pc_reg;
  assign nop     = nop_reg;

endmodule

// File: tb/tb_core_fetch_queue.sv
// Scoreboard bench for core_fetch_queue driving a bus model that returns data_rd = addr.
module tb_core_fetch_queue;
  import core_fetch_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [29:0] target;
  logic        start;
  logic [29:0] addr;
  logic        ready;
  logic [31:0] data_rd;
  logic [31:0] insn;
  logic [29:0] insn_pc;
  logic        nop;

  core_fetch_queue #(
    .ORDER(2),
    .NOP  (32'he1a00000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .stall  (stall),
    .flush  (flush),
    .target (target),
    .start  (start),
    .addr   (addr),
    .ready  (ready),
    .data_rd(data_rd),
    .insn   (insn),
    .insn_pc(insn_pc),
    .nop    (nop)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_entry_t sb[$];
  logic [29:0]  addr_log[$];

  // bus model: one pending request with its own latency countdown
  logic        pend = 1'b0;
  logic [29:0] pend_addr = '0;
  int          pend_cnt = 0;
  logic        pend_taint = 1'b0;
  int          bus_lat = 1;

  logic [29:0] exp_addr = '0;
  logic        prev_flush = 1'b1;
  logic        prev_pop = 1'b0;
  logic [31:0] held_insn;
  logic [29:0] held_pc;
  logic        held_nop;
  logic        last_start;
  int          n_starts = 0;
  int          cyc = 0;
  int          drop_cyc = -1;
  int          target_cyc = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input logic s_i, input logic f_i, input logic [29:0] t_i);
    logic resp_now;
    fetch_entry_t e;
    stall    = s_i;
    flush    = f_i;
    target   = t_i;
    resp_now = pend && (pend_cnt == 1);
    ready    = resp_now;
    data_rd  = resp_now ? {2'b00, pend_addr} : 32'hdeadbeef;
    #1;
    if (prev_flush) begin
      check("flush_nop", nop, 1);
      check("flush_insn", insn, NOP_INSN);
    end else if (prev_pop) begin
      check("nop", nop, (sb.size() == 0));
      if (!nop && sb.size() > 0) begin
        e = sb.pop_front();
        check("insn", insn, e.insn);
        check("insn_pc", insn_pc, e.pc);
        $display("[TB] cyc %0d insn %h pc %h", cyc, insn, insn_pc);
        if (insn_pc == 30'h100 && target_cyc < 0) target_cyc = cyc;
      end
    end else begin
      check("hold_insn", insn, held_insn);
      check("hold_pc", insn_pc, held_pc);
      check("hold_nop", nop, held_nop);
    end
    held_insn  = insn;
    held_pc    = insn_pc;
    held_nop   = nop;
    last_start = start;
    if (resp_now) begin
      if (pend_taint || f_i) begin
        if (pend_taint) drop_cyc = cyc;
      end else begin
        sb.push_back('{insn: {2'b00, pend_addr}, pc: pend_addr});
      end
      pend = 1'b0;
    end else if (pend) begin
      pend_cnt--;
      if (f_i) pend_taint = 1'b1;
    end
    if (start) begin
      check("one_outstanding", pend, 0);
      check("addr", addr, exp_addr);
      n_starts++;
      addr_log.push_back(addr);
      pend       = 1'b1;
      pend_addr  = addr;
      pend_cnt   = bus_lat;
      pend_taint = 1'b0;
      exp_addr   = addr + 30'd1;
    end
    if (f_i) begin
      sb.delete();
      exp_addr = t_i;
    end
    prev_flush = f_i;
    prev_pop   = !s_i && !f_i;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start();
    last_start = 1'b0;
    for (int i = 0; i < 20 && !last_start; i++) tick(0, 0, '0);
    check("wait_start", last_start, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; target = '0; ready = 1'b0; data_rd = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_nop", nop, 1);
      check("rst_insn", insn, 32'he1a00000);
      check("rst_start", start, 0);
    end
    rst = 1'b0;
    #1;
    check("first_start", start, 1);
    check("first_addr", addr, 0);

    // steady zero-wait fetch
    repeat (16) tick(0, 0, '0);

    // stall starting on an issue cycle with an empty queue
    wait_start();
    tick(0, 0, '0);
    n0 = n_starts;
    repeat (10) tick(1, 0, '0);
    check("stall_starts", n_starts - n0, 4);
    repeat (12) tick(0, 0, '0);

    // flush while a slow request is still in flight
    bus_lat = 3;
    wait_start();
    tick(0, 1, 30'h100);
    bus_lat = 1;
    repeat (10) tick(0, 0, '0);
    check("redirect_lat", target_cyc - drop_cyc, 3);

    // flush coinciding with ready, then with ready and stall
    wait_start();
    tick(0, 1, 30'h200);
    repeat (6) tick(0, 0, '0);
    wait_start();
    tick(1, 1, 30'h300);
    repeat (6) tick(0, 0, '0);

    // fetch address wrap
    tick(0, 1, 30'h3fffffff);
    addr_log.delete();
    repeat (8) tick(0, 0, '0);
    check("wrap_count", (addr_log.size() >= 2), 1);
    if (addr_log.size() >= 2) begin
      check("wrap_addr0", addr_log[0], 32'h3fffffff);
      check("wrap_addr1", addr_log[1], 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
